// File: rtl/jtag_pkg.sv
// Shared TAP definitions: controller state encoding (standard 1149.1 codes),
// instruction opcodes and the fixed IR capture pattern.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'hF,
    RUN_TEST_IDLE    = 4'hC,
    SELECT_DR        = 4'h7,
    CAPTURE_DR       = 4'h6,
    SHIFT_DR         = 4'h2,
    EXIT1_DR         = 4'h1,
    PAUSE_DR         = 4'h3,
    EXIT2_DR         = 4'h0,
    UPDATE_DR        = 4'h5,
    SELECT_IR        = 4'h4,
    CAPTURE_IR       = 4'hE,
    SHIFT_IR         = 4'hA,
    EXIT1_IR         = 4'h9,
    PAUSE_IR         = 4'hB,
    EXIT2_IR         = 4'h8,
    UPDATE_IR        = 4'hD
  } tap_state_e;

  localparam logic [3:0] INSTR_IDCODE = 4'b0001;
  localparam logic [3:0] INSTR_USER   = 4'b0010;
  localparam logic [3:0] INSTR_BYPASS = 4'b1111;
  localparam logic [3:0] IR_CAPTURE   = 4'b0101;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller. Strobes are registered alongside the state so they
// are glitch-free decodes of the current state.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  tap_state_e state_q, state_d;
  logic capture_dr_q, shift_dr_q, update_dr_q;
  logic capture_ir_q, shift_ir_q, update_ir_q;
  logic capture_dr_d, shift_dr_d, update_dr_d;
  logic capture_ir_d, shift_ir_d, update_ir_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        state_d = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         state_d = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         state_d = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         state_d = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         state_d = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        state_d = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         state_d = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         state_d = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         state_d = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         state_d = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        state_d = tms ? SELECT_DR : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
    capture_dr_d = (state_d == CAPTURE_DR);
    shift_dr_d   = (state_d == SHIFT_DR);
    update_dr_d  = (state_d == UPDATE_DR);
    capture_ir_d = (state_d == CAPTURE_IR);
    shift_ir_d   = (state_d == SHIFT_IR);
    update_ir_d  = (state_d == UPDATE_IR);
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q      <= TEST_LOGIC_RESET;
      capture_dr_q <= 1'b0;
      shift_dr_q   <= 1'b0;
      update_dr_q  <= 1'b0;
      capture_ir_q <= 1'b0;
      shift_ir_q   <= 1'b0;
      update_ir_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      capture_dr_q <= capture_dr_d;
      shift_dr_q   <= shift_dr_d;
      update_dr_q  <= update_dr_d;
      capture_ir_q <= capture_ir_d;
      shift_ir_q   <= shift_ir_d;
      update_ir_q  <= update_ir_d;
    end
  end

  assign state      = state_q;
  assign capture_dr = capture_dr_q;
  assign shift_dr   = shift_dr_q;
  assign update_dr  = update_dr_q;
  assign capture_ir = capture_ir_q;
  assign shift_ir   = shift_ir_q;
  assign update_ir  = update_ir_q;

endmodule

// File: rtl/jtag_tap_slave.sv
// JTAG TAP slave: IR plus BYPASS/IDCODE/USER data registers. Capture and shift
// act on posedge tck; update registers and tdo change on negedge tck.
module jtag_tap_slave
  import jtag_pkg::*;
#(
  parameter int                    IR_WIDTH   = 4,
  parameter logic [31:0]           IDCODE_VAL = 32'h1495_11C3,
  parameter int                    USER_WIDTH = 32,
  parameter logic [USER_WIDTH-1:0] USER_RESET = '0
) (
  input  logic tck,
  input  logic trst,
  input  logic tdi,
  input  logic tms,
  output logic tdo
);

  tap_state_e state;
  logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .state      (state),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir)
  );

  logic [IR_WIDTH-1:0]   ir_shift_q, ir_shift_d, ir_q, ir_d;
  logic [31:0]           idcode_shift_q, idcode_shift_d;
  logic [USER_WIDTH-1:0] user_shift_q, user_shift_d, user_q, user_d;
  logic                  bypass_q, bypass_d;
  logic                  tdo_q, tdo_d;
  logic                  sel_idcode, sel_user, dr_lsb;

  // Every opcode other than IDCODE and USER falls through to BYPASS.
  assign sel_idcode = (ir_q == IR_WIDTH'(INSTR_IDCODE));
  assign sel_user   = (ir_q == IR_WIDTH'(INSTR_USER));

  always_comb begin
    ir_shift_d     = ir_shift_q;
    idcode_shift_d = idcode_shift_q;
    user_shift_d   = user_shift_q;
    bypass_d       = bypass_q;
    if (capture_ir) begin
      ir_shift_d = IR_WIDTH'(IR_CAPTURE);
    end else if (shift_ir) begin
      ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
    end
    if (capture_dr) begin
      if (sel_idcode)    idcode_shift_d = IDCODE_VAL;
      else if (sel_user) user_shift_d   = user_q;
      else               bypass_d       = 1'b0;
    end else if (shift_dr) begin
      if (sel_idcode)    idcode_shift_d = {tdi, idcode_shift_q[31:1]};
      else if (sel_user) user_shift_d   = {tdi, user_shift_q[USER_WIDTH-1:1]};
      else               bypass_d       = tdi;
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_shift_q     <= '0;
      idcode_shift_q <= '0;
      user_shift_q   <= '0;
      bypass_q       <= 1'b0;
    end else begin
      ir_shift_q     <= ir_shift_d;
      idcode_shift_q <= idcode_shift_d;
      user_shift_q   <= user_shift_d;
      bypass_q       <= bypass_d;
    end
  end

  always_comb begin
    dr_lsb = sel_idcode ? idcode_shift_q[0] : (sel_user ? user_shift_q[0] : bypass_q);
    ir_d   = ir_q;
    user_d = user_q;
    if (state == TEST_LOGIC_RESET) begin
      ir_d = IR_WIDTH'(INSTR_IDCODE);
    end else if (update_ir) begin
      ir_d = ir_shift_q;
    end
    if (update_dr && sel_user) begin
      user_d = user_shift_q;
    end
    tdo_d = shift_ir ? ir_shift_q[0] : (shift_dr ? dr_lsb : 1'b0);
  end

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      ir_q   <= IR_WIDTH'(INSTR_IDCODE);
      user_q <= USER_RESET;
      tdo_q  <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      user_q <= user_d;
      tdo_q  <= tdo_d;
    end
  end

  assign tdo = tdo_q;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Directed bench for jtag_tap_slave: resets, IR/DR scans, bypass delay,
// pause/resume, overshift and trst abort, checked against hand-derived values.
module tb_jtag_tap_slave;
  import jtag_pkg::*;

  logic tck = 1'b0;
  logic trst = 1'b0;
  logic tdi = 1'b0;
  logic tms = 1'b1;
  logic tdo;

  int vectors = 0;
  int miscompares = 0;

  jtag_tap_slave dut (
    .tck  (tck),
    .trst (trst),
    .tdi  (tdi),
    .tms  (tms),
    .tdo  (tdo)
  );

  always #10 tck = ~tck;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at negedge+1: capture tdo as the master would at the coming posedge.
  task automatic tick(input logic tms_v, input logic tdi_v, output logic tdo_v);
    tdo_v = tdo;
    tms   = tms_v;
    tdi   = tdi_v;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic tms_step(input logic v);
    logic d;
    tick(v, 1'b0, d);
  endtask

  task automatic shift_bits(input int n, input logic [63:0] din, input logic exit_last,
                            output logic [63:0] dout);
    logic b;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tick(exit_last && (i == n - 1), din[i], b);
      dout[i] = b;
    end
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
    tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
    shift_bits(n, din, 1'b1, dout);
    tms_step(1'b1); tms_step(1'b0);
  endtask

  task automatic ir_scan(input logic [3:0] din, output logic [3:0] dout);
    logic [63:0] d;
    tms_step(1'b1); tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
    shift_bits(4, {60'd0, din}, 1'b1, d);
    dout = d[3:0];
    tms_step(1'b1); tms_step(1'b0);
  endtask

  initial begin
    logic [63:0] r, r2;
    logic [3:0]  ir_r;

    // Reset held low
    @(negedge tck); #1;
    check("rst_state", 64'(dut.state), 64'(TEST_LOGIC_RESET));
    check("rst_ir",    64'(dut.ir_q), 64'h1);
    check("rst_tdo",   64'(tdo), 64'h0);
    trst = 1'b1;

    for (int i = 0; i < 5; i++) tms_step(1'b1);
    tms_step(1'b0);
    check("rti_state", 64'(dut.state), 64'(RUN_TEST_IDLE));
    check("rti_ir",    64'(dut.ir_q), 64'h1);
    check("rti_tdo",   64'(tdo), 64'h0);

    dr_scan(32, 64'h0, r);
    check("idcode_read", r, 64'h1495_11C3);

    ir_scan(4'b0010, ir_r);
    check("ir_capture_user", 64'(ir_r), 64'h5);
    check("ir_is_user", 64'(dut.ir_q), 64'h2);
    dr_scan(32, 64'hDEAD_BEEF, r);
    check("user_reset_val", r, 64'h0);
    dr_scan(32, 64'h1357_9BDF, r);
    check("user_readback", r, 64'hDEAD_BEEF);

    // tms-driven reset reloads IR but keeps USER
    for (int i = 0; i < 5; i++) tms_step(1'b1);
    tms_step(1'b0);
    check("tms_rst_ir", 64'(dut.ir_q), 64'h1);
    ir_scan(4'b0010, ir_r);
    dr_scan(32, 64'h0000_0000, r);
    check("user_kept", r, 64'h1357_9BDF);
    // restore a non-reset USER value for the trst abort check
    dr_scan(32, 64'h1357_9BDF, r);
    check("user_cleared_by_write", r, 64'h0);

    ir_scan(4'b1111, ir_r);
    check("ir_capture_bypass", 64'(ir_r), 64'h5);
    dr_scan(8, 64'hB2, r);
    check("bypass_delay", r, 64'h64);

    ir_scan(4'b0110, ir_r);
    dr_scan(4, 64'hF, r);
    check("unknown_is_bypass", r, 64'hE);

    ir_scan(4'b0001, ir_r);
    check("ir_capture_idcode", 64'(ir_r), 64'h5);
    dr_scan(40, 64'hA5, r);
    check("idcode_overshift", r, 64'hA5_1495_11C3);

    // Pause mid-shift, resume via EXIT2
    tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
    shift_bits(10, 64'h0, 1'b1, r);
    tms_step(1'b0);
    tms_step(1'b0); tms_step(1'b0); tms_step(1'b0);
    check("pause_state", 64'(dut.state), 64'(PAUSE_DR));
    tms_step(1'b1); tms_step(1'b0);
    shift_bits(22, 64'h0, 1'b1, r2);
    tms_step(1'b1); tms_step(1'b0);
    check("pause_resume", {r2[21:0], r[9:0]}, 64'h1495_11C3);

    // trst during a USER write aborts it
    ir_scan(4'b0010, ir_r);
    tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
    shift_bits(16, 64'hFFFF, 1'b0, r);
    check("mid_scan_state", 64'(dut.state), 64'(SHIFT_DR));
    trst = 1'b0;
    #1;
    check("trst_state", 64'(dut.state), 64'(TEST_LOGIC_RESET));
    check("trst_tdo",   64'(tdo), 64'h0);
    check("trst_ir",    64'(dut.ir_q), 64'h1);
    @(negedge tck); #1;
    trst = 1'b1;
    tms_step(1'b0);
    check("post_trst_rti", 64'(dut.state), 64'(RUN_TEST_IDLE));
    ir_scan(4'b0010, ir_r);
    dr_scan(32, 64'h0, r);
    check("user_after_trst", r, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
